// File: rtl/mem_arbiter_pkg.sv
// Shared defaults and FSM encoding for the two-requester memory arbiter.
package mem_ctrl_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF  = 5;
  localparam int NUM_REQ    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-facing bus of the arbiter: per-requester request fields plus
// the shared grant/ack/response returned by the arbiter.
interface mem_arbiter_if #(
  parameter int DATA_W = mem_ctrl_pkg::DATA_W_DEF,
  parameter int ADDR_W = mem_ctrl_pkg::ADDR_W_DEF
);
  logic [1:0]        ireq;
  logic [1:0]        iwe;
  logic [ADDR_W-1:0] iaddr0;
  logic [ADDR_W-1:0] iaddr1;
  logic [DATA_W-1:0] idata0;
  logic [DATA_W-1:0] idata1;
  logic [1:0]        ogrant;
  logic [1:0]        oack;
  logic [DATA_W-1:0] odata;
  logic              oerr;

  modport master (
    output ireq, iwe, iaddr0, iaddr1, idata0, idata1,
    input  ogrant, oack, odata, oerr
  );

  modport slave (
    input  ireq, iwe, iaddr0, iaddr1, idata0, idata1,
    output ogrant, oack, odata, oerr
  );
endinterface

// File: rtl/mem_arbiter_bank.sv
// DEPTH x DATA_W storage with a registered read and strobe-gated write.
// Words power up holding their own address; there is no reset, so a reset
// of the arbiter never disturbs stored data.
module mem_bank
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              iclk,
  input  logic              iwe,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  output logic [DATA_W-1:0] odata
);
  logic [DEPTH-1:0][DATA_W-1:0] words;

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    logic [DATA_W-1:0] word_q = DATA_W'(k);
    // Write this word only when the strobe is up and the address matches
    always_ff @(posedge iclk)
      if (iwe && iaddr == ADDR_W'(k)) word_q <= idata;
    assign words[k] = word_q;
  end

  // Registered read; out-of-range addresses read back as zero
  always_ff @(posedge iclk)
    odata <= (32'(iaddr) < DEPTH) ? words[iaddr] : '0;
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory bank.
// Each transaction walks IDLE -> ACCESS -> RESP, one per three cycles.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic arb_iclk,
  input  logic arb_irst_n,
  mem_arbiter_if.slave bus
);
  arb_state_e                        state;
  logic [NUM_REQ-1:0]                grant_q, ack_q;
  logic                              err_q, rd_ok_q, last_q;
  logic                              lat_we;
  logic [ADDR_W-1:0]                 lat_addr;
  logic [DATA_W-1:0]                 lat_data, rd_data;
  logic [NUM_REQ-1:0][ADDR_W-1:0]    addr_v;
  logic [NUM_REQ-1:0][DATA_W-1:0]    data_v;
  logic                              win, in_range, mem_we;

  assign addr_v = {bus.iaddr1, bus.iaddr0};
  assign data_v = {bus.idata1, bus.idata0};

  // Lone requester wins outright; on a tie the one not served last wins
  assign win = (bus.ireq == 2'b11) ? ~last_q : bus.ireq[1];

  assign in_range = 32'(lat_addr) < DEPTH;
  // Strobe lives only in ACCESS; async reset drops state so it falls at once
  assign mem_we   = (state == ACCESS) && lat_we && in_range;

  mem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank (
    .iclk (arb_iclk),
    .iwe  (mem_we),
    .iaddr(lat_addr),
    .idata(lat_data),
    .odata(rd_data)
  );

  // Arbitration FSM with registered grant/ack/err
  always_ff @(posedge arb_iclk or negedge arb_irst_n)
    if (!arb_irst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
      last_q   <= 1'b1;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else begin
      case (state)
        IDLE:
          if (|bus.ireq) begin
            state    <= ACCESS;
            grant_q  <= {win, ~win};
            last_q   <= win;
            lat_we   <= bus.iwe[win];
            lat_addr <= addr_v[win];
            lat_data <= data_v[win];
          end
        ACCESS: begin
          state   <= RESP;
          ack_q   <= grant_q;
          err_q   <= ~in_range;
          rd_ok_q <= in_range & ~lat_we;
        end
        RESP: begin
          state   <= IDLE;
          grant_q <= '0;
          ack_q   <= '0;
          err_q   <= 1'b0;
          rd_ok_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end

  assign bus.ogrant = grant_q;
  assign bus.oack   = ack_q;
  assign bus.oerr   = err_q;
  assign bus.odata  = rd_ok_q ? rd_data : '0;
endmodule
